add_sub_unit: RTL and testbench

Parametrised registered add/subtract execution unit for the basic processor datapath. It generalises the 8-bit add/sub block with configurable width, carry-in ops, saturating add, compare and a full flag set. It uses a start/busy/done handshake with a programmable done-hold window that replaces the fixed 3-cycle ctr2 pulse. It sits between the register-file read ports and the writeback mux, and is decoded from the same 4-bit ctrl opcode field.

---
 rtl/add_sub_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_add_sub_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_unit.sv
// -----------------------------------------------------------------------------
// add_sub_unit
//
// Registered add/subtract execution unit for the processor datapath. An
// operation is captured on a start request while the unit is idle. The unit
// computes the operation for one cycle (EXEC). It then presents result and
// flags with done held high for DONE_HOLD cycles (HOLD). The ctrl opcode field
// is the same 4-bit field that the writeback path decodes.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   DONE_HOLD  number of cycles done stays high per operation (>= 1)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, accepted only when the unit can take it
//   ctrl    in   4-bit opcode, captured with start
//   a, b    in   WIDTH-bit operands, captured with start
//   cin     in   carry-in for ADC/SBB, captured with start
//   result  out  registered result (CMP leaves it unchanged)
//   cout    out  carry flag (1 = carry out / no borrow)
//   zero    out  computed value == 0
//   neg     out  MSB of computed value
//   ovf     out  signed overflow
//   done    out  result/flags valid, high for DONE_HOLD cycles
//   busy    out  high whenever the FSM is not idle
//   err     out  one-cycle pulse after a start with an unsupported opcode
// -----------------------------------------------------------------------------
module add_sub_unit #(
    parameter int WIDTH     = 8,
    parameter int DONE_HOLD = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SBB  = 4'h6;
    localparam logic [3:0] OP_ADDS = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h9;

    // The hold counter needs to count at least from DONE_HOLD-1 down to 0.
    localparam int CW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(DONE_HOLD - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Opcode decode shared by the IDLE and done-fall accept paths.
    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_ADDS, OP_CMP: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;

    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             zero_r;
    logic             neg_r;
    logic             ovf_r;
    logic             done_r;
    logic             busy_r;
    logic             err_r;

    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] val_s;
    logic             ovf_s;
    logic             sat_s;

    // Operand selection: subtracting ops use ~b, and the carry-in depends on the opcode.
    always_comb begin
        b_eff_s = b_r;
        c_eff_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                b_eff_s = b_r;
                c_eff_s = 1'b0;
            end
            OP_SUB, OP_CMP: begin
                b_eff_s = ~b_r;
                c_eff_s = 1'b1;
            end
            OP_ADC: begin
                b_eff_s = b_r;
                c_eff_s = cin_r;
            end
            OP_SBB: begin
                b_eff_s = ~b_r;
                c_eff_s = cin_r;
            end
            OP_ADDS: begin
                b_eff_s = b_r;
                c_eff_s = 1'b0;
            end
            default: begin
                b_eff_s = b_r;
                c_eff_s = 1'b0;
            end
        endcase
    end

    // The adder works at WIDTH+1 bits, so the top bit is the carry flag.
    // Saturation affects only the written value. cout and ovf report the raw sum.
    always_comb begin
        sum_s = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, c_eff_s};
        sat_s = (op_r == OP_ADDS) && sum_s[WIDTH];
        if (sat_s) begin
            val_s = {WIDTH{1'b1}};
        end else begin
            val_s = sum_s[WIDTH-1:0];
        end
        ovf_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            op_r     <= 4'h0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            cin_r    <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && op_supported(ctrl)) begin
                        op_r    <= ctrl;
                        a_r     <= a;
                        b_r     <= b;
                        cin_r   <= cin;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (op_r != OP_CMP) begin
                        result_r <= val_s;
                    end else begin
                        result_r <= result_r;
                    end
                    cout_r  <= sum_s[WIDTH];
                    zero_r  <= (val_s == {WIDTH{1'b0}});
                    neg_r   <= val_s[WIDTH-1];
                    ovf_r   <= ovf_s;
                    done_r  <= 1'b1;
                    cnt_r   <= HOLD_LOAD;
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        // The edge where done falls also accepts a new request,
                        // so a start that is held high chains straight into the next op.
                        done_r <= 1'b0;
                        if (start && op_supported(ctrl)) begin
                            op_r    <= ctrl;
                            a_r     <= a;
                            b_r     <= b;
                            cin_r   <= cin;
                            busy_r  <= 1'b1;
                            state_r <= ST_EXEC;
                        end else if (start) begin
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = result_r;
    assign cout   = cout_r;
    assign zero   = zero_r;
    assign neg    = neg_r;
    assign ovf    = ovf_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign err    = err_r;

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit. It instantiates an 8-bit/hold-3 unit
// and a 16-bit/hold-1 unit. Expected values come from an integer-arithmetic
// model of the opcode rules.
module tb_add_sub_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [3:0]  ctrl_in = 4'h0;
    logic [15:0] a_in = 16'h0;
    logic [15:0] b_in = 16'h0;
    logic        cin_in = 1'b0;

    logic [7:0]  r8;
    logic        co8, z8, n8, v8, d8, b8, e8;
    logic [15:0] r16;
    logic        co16, z16, n16, v16, d16, b16, e16;

    logic        sel = 1'b0;
    logic [15:0] o_res;
    logic        o_cout, o_zero, o_neg, o_ovf, o_done, o_busy, o_err;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_prev [2] = '{0, 0};

    add_sub_unit #(.WIDTH(8), .DONE_HOLD(3)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ctrl(ctrl_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
        .result(r8), .cout(co8), .zero(z8), .neg(n8), .ovf(v8),
        .done(d8), .busy(b8), .err(e8)
    );

    add_sub_unit #(.WIDTH(16), .DONE_HOLD(1)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .ctrl(ctrl_in),
        .a(a_in), .b(b_in), .cin(cin_in),
        .result(r16), .cout(co16), .zero(z16), .neg(n16), .ovf(v16),
        .done(d16), .busy(b16), .err(e16)
    );

    always #5 clk = ~clk;

    // Route the outputs of the selected instance to one set of observation signals.
    always_comb begin
        o_res  = sel ? r16  : {8'h00, r8};
        o_cout = sel ? co16 : co8;
        o_zero = sel ? z16  : z8;
        o_neg  = sel ? n16  : n8;
        o_ovf  = sel ? v16  : v8;
        o_done = sel ? d16  : d8;
        o_busy = sel ? b16  : b8;
        o_err  = sel ? e16  : e8;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit supported(input logic [3:0] op);
        return (op == 4'h2) || (op == 4'h3) || (op == 4'h5) ||
               (op == 4'h6) || (op == 4'h7) || (op == 4'h9);
    endfunction

    // Reference model. It computes the op as unsigned integers modulo 2^w and
    // derives the signed overflow from the signed integer sum.
    function automatic void model(input int w, input logic [3:0] op, input int av, input int bv,
                                  input int cv, input int prev,
                                  output int res, output int co, output int z,
                                  output int ng, output int ov);
        int md, half, bp, c, s, v, sa, sb, ss;
        md = 1 << w;
        half = md / 2;
        bp = bv;
        c = 0;
        case (op)
            4'h3, 4'h9: begin bp = md - 1 - bv; c = 1; end
            4'h5:       c = cv;
            4'h6:       begin bp = md - 1 - bv; c = cv; end
            default:    begin bp = bv; c = 0; end
        endcase
        s = av + bp + c;
        co = (s >= md) ? 1 : 0;
        v = s % md;
        if (op == 4'h7 && co == 1) v = md - 1;
        sa = (av >= half) ? av - md : av;
        sb = (bp >= half) ? bp - md : bp;
        ss = sa + sb + c;
        ov = (ss > half - 1 || ss < -half) ? 1 : 0;
        z = (v == 0) ? 1 : 0;
        ng = (v >= half) ? 1 : 0;
        res = (op == 4'h9) ? prev : v;
    endfunction

    // Issue one op on the selected instance, then check the latency, the values and the done length.
    task automatic do_op(input logic [3:0] op, input int av, input int bv, input logic cv);
        int w, h, e_res, e_co, e_z, e_n, e_v, n;
        w = sel ? 16 : 8;
        h = sel ? 1 : 3;
        @(negedge clk);
        ctrl_in = op;
        a_in = 16'(av);
        b_in = 16'(bv);
        cin_in = cv;
        start8 = (sel == 1'b0);
        start16 = (sel == 1'b1);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        if (!supported(op)) begin
            check_eq("err_pulse", 32'(o_err), 32'd1);
            check_eq("err_busy", 32'(o_busy), 32'd0);
            @(posedge clk);
            #1;
            check_eq("err_clear", 32'(o_err), 32'd0);
            check_eq("err_result_kept", 32'(o_res), 32'(exp_prev[sel]));
            return;
        end
        model(w, op, av, bv, int'(cv), exp_prev[sel], e_res, e_co, e_z, e_n, e_v);
        exp_prev[sel] = e_res;
        check_eq("exec_busy", 32'(o_busy), 32'd1);
        check_eq("exec_done", 32'(o_done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("done_rise", 32'(o_done), 32'd1);
        check_eq("result", 32'(o_res), 32'(e_res));
        check_eq("cout", 32'(o_cout), 32'(e_co));
        check_eq("zero", 32'(o_zero), 32'(e_z));
        check_eq("neg", 32'(o_neg), 32'(e_n));
        check_eq("ovf", 32'(o_ovf), 32'(e_v));
        n = 0;
        while (o_done && n < 50) begin
            n++;
            check_eq("hold_busy", 32'(o_busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check_eq("done_len", 32'(n), 32'(h));
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("result_kept", 32'(o_res), 32'(e_res));
    endtask

    logic [3:0] op_tab [7] = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};

    initial begin
        // Reset state
        #12;
        check_eq("rst_result8", 32'(r8), 32'd0);
        check_eq("rst_flags8", 32'({co8, z8, n8, v8, d8, b8, e8}), 32'd0);
        check_eq("rst_result16", 32'(r16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on the 8-bit, hold-3 instance
        sel = 1'b0;
        do_op(4'h2, 8'h7F, 8'h01, 1'b0);
        do_op(4'h3, 8'h05, 8'h05, 1'b0);
        do_op(4'h6, 8'h00, 8'h01, 1'b1);
        do_op(4'h5, 8'hFF, 8'h00, 1'b1);
        do_op(4'h7, 8'hF0, 8'h20, 1'b0);
        do_op(4'h2, 8'h50, 8'h05, 1'b0);
        do_op(4'h9, 8'h10, 8'h20, 1'b0);
        check_eq("cmp_keeps_55", 32'(r8), 32'h55);

        // Start held high through busy: one op only, then a second op is accepted where done falls
        @(negedge clk);
        ctrl_in = 4'h2; a_in = 16'd1; b_in = 16'd1; start8 = 1'b1;
        @(posedge clk); #1;
        a_in = 16'd3; b_in = 16'd3;
        check_eq("hold_exec_busy", 32'(b8), 32'd1);
        @(posedge clk); #1;
        check_eq("hold_first_res", 32'(r8), 32'd2);
        check_eq("hold_first_done", 32'(d8), 32'd1);
        @(posedge clk); #1;
        check_eq("hold_done2", 32'(d8), 32'd1);
        @(posedge clk); #1;
        check_eq("hold_done3", 32'(d8), 32'd1);
        @(posedge clk); #1;
        start8 = 1'b0;
        check_eq("accept_done_low", 32'(d8), 32'd0);
        check_eq("accept_busy", 32'(b8), 32'd1);
        @(posedge clk); #1;
        check_eq("second_res", 32'(r8), 32'd6);
        check_eq("second_done", 32'(d8), 32'd1);
        exp_prev[0] = 6;
        repeat (3) @(posedge clk);
        #1;
        check_eq("second_idle", 32'(b8), 32'd0);

        // Unsupported opcode, single and back-to-back
        do_op(4'hF, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        ctrl_in = 4'h0; start8 = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_err1", 32'(e8), 32'd1);
        @(posedge clk); #1;
        start8 = 1'b0;
        check_eq("b2b_err2", 32'(e8), 32'd1);
        @(posedge clk); #1;
        check_eq("b2b_err_end", 32'(e8), 32'd0);
        check_eq("b2b_busy", 32'(b8), 32'd0);
        check_eq("b2b_result", 32'(r8), 32'd6);

        // Asynchronous reset in the middle of HOLD
        @(negedge clk);
        ctrl_in = 4'h2; a_in = 16'h40; b_in = 16'h41; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #3;
        check_eq("pre_rst_done", 32'(d8), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_result", 32'(r8), 32'd0);
        check_eq("async_rst_flags", 32'({co8, z8, n8, v8, d8, b8, e8}), 32'd0);
        exp_prev[0] = 0;
        exp_prev[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h2, 8'h01, 8'h02, 1'b0);

        // 16-bit, hold-1 instance
        sel = 1'b1;
        do_op(4'h2, 16'hFFFF, 16'h0001, 1'b0);
        do_op(4'h3, 16'h0000, 16'h0001, 1'b0);

        // Randomized ops on both instances
        for (int i = 0; i < 60; i++) begin
            int w, av, bv;
            logic [3:0] op;
            sel = 1'($urandom_range(0, 1));
            w = sel ? 16 : 8;
            op = op_tab[$urandom_range(0, 6)];
            av = int'($urandom_range(0, (1 << w) - 1));
            bv = int'($urandom_range(0, (1 << w) - 1));
            do_op(op, av, bv, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
